// File: rtl/pixel_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : pixel_mem_arbiter
// Description : Shares a single-port, 1-cycle-latency pixel memory between
//               the display fetch path (absolute priority, timed from the
//               raster counters with 3-cycle lookahead) and a write requester
//               that takes every remaining cycle. A 160x120 framebuffer is
//               shown at 4x scale on a 640x480 raster.
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_mem_arbiter #(
    parameter int H_ACTIVE = 640,
    parameter int H_TOTAL  = 800,
    parameter int V_ACTIVE = 480,
    parameter int V_TOTAL  = 525,
    parameter int FB_W     = 160,
    parameter int ADDR_W   = 15
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [9:0]        x_i,
    input  logic [9:0]        y_i,
    input  logic              wr_req_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [2:0]        wr_data_i,
    output logic              wr_ack_o,
    output logic              wr_err_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [2:0]        mem_wdata_o,
    input  logic [2:0]        mem_rdata_i,
    output logic [2:0]        rgb_o
);

    localparam int                FB_DEPTH = FB_W * V_ACTIVE / 4;
    localparam logic [10:0]       HTOT_11  = 11'(H_TOTAL);
    localparam logic [10:0]       HACT_11  = 11'(H_ACTIVE);
    localparam logic [9:0]        HACT_10  = 10'(H_ACTIVE);
    localparam logic [9:0]        VACT_10  = 10'(V_ACTIVE);
    localparam logic [9:0]        VLAST_10 = 10'(V_TOTAL - 1);
    localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(FB_DEPTH);

    // Per-cycle ownership of the memory port; DISP always beats WR.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DISP = 2'd1,
        S_WR   = 2'd2
    } state_t;

    state_t            state;
    logic              rd_pend;
    logic [2:0]        pix;

    logic [10:0]       x_plus3;
    logic              wrap_line;
    logic [10:0]       fx;
    logic [9:0]        fy;
    logic              disp_slot;
    logic [ADDR_W-1:0] row;
    logic [ADDR_W-1:0] col;
    logic [ADDR_W-1:0] disp_addr;
    logic              wr_grant;
    logic              wr_oob;

    // Fetch coordinates three pixels ahead, wrapping across line and frame.
    always_comb begin
        x_plus3   = {1'b0, x_i} + 11'd3;
        wrap_line = (x_plus3 >= HTOT_11);
        fx        = wrap_line ? (x_plus3 - HTOT_11) : x_plus3;
        if (!wrap_line) begin
            fy = y_i;
        end else if (y_i == VLAST_10) begin
            fy = 10'd0;
        end else begin
            fy = y_i + 10'd1;
        end
    end

    // Slot test and block address; row*160 is built as row*128 + row*32.
    always_comb begin
        disp_slot = (fx < HACT_11) && (fy < VACT_10) && (fx[1:0] == 2'b00);
        row       = ADDR_W'(fy[9:2]);
        col       = ADDR_W'(fx[9:2]);
        disp_addr = (row << 7) + (row << 5) + col;
        wr_grant  = wr_req_i && !disp_slot && !wr_ack_o;
        wr_oob    = (wr_addr_i >= DEPTH_A);
    end

    // Arbitration FSM: decision in cycle t drives the command registers in t+1.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state       <= S_IDLE;
            rd_pend     <= 1'b0;
            wr_ack_o    <= 1'b0;
            wr_err_o    <= 1'b0;
            mem_en_o    <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= 3'd0;
        end else begin
            // Read data returns the cycle after a display read is on the port.
            rd_pend <= (state == S_DISP);
            if (disp_slot) begin
                state      <= S_DISP;
                wr_ack_o   <= 1'b0;
                wr_err_o   <= 1'b0;
                mem_en_o   <= 1'b1;
                mem_we_o   <= 1'b0;
                mem_addr_o <= disp_addr;
            end else if (wr_grant) begin
                wr_ack_o <= 1'b1;
                wr_err_o <= wr_oob;
                if (wr_oob) begin
                    // Consume the request without touching memory.
                    state    <= S_IDLE;
                    mem_en_o <= 1'b0;
                    mem_we_o <= 1'b0;
                end else begin
                    state       <= S_WR;
                    mem_en_o    <= 1'b1;
                    mem_we_o    <= 1'b1;
                    mem_addr_o  <= wr_addr_i;
                    mem_wdata_o <= wr_data_i;
                end
            end else begin
                state    <= S_IDLE;
                wr_ack_o <= 1'b0;
                wr_err_o <= 1'b0;
                mem_en_o <= 1'b0;
                mem_we_o <= 1'b0;
            end
        end
    end

    // Pixel register captures returned read data and holds it for the block.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pix <= 3'd0;
        end else if (rd_pend) begin
            pix <= mem_rdata_i;
        end
    end

    assign rgb_o = ((x_i < HACT_10) && (y_i < VACT_10)) ? pix : 3'd0;

endmodule
`default_nettype wire

// File: tb/tb_pixel_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_pixel_mem_arbiter
// Description : Randomized self-checking bench for pixel_mem_arbiter with a
//               cycle-level reference model, a memory model and directed
//               raster/write scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pixel_mem_arbiter;

    localparam int H_ACTIVE = 640;
    localparam int H_TOTAL  = 800;
    localparam int V_ACTIVE = 480;
    localparam int V_TOTAL  = 525;
    localparam int FB_W     = 160;
    localparam int ADDR_W   = 15;
    localparam int DEPTH    = 19200;
    localparam int MEM_N    = 32768;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b0;
    logic [9:0]        x_i = '0;
    logic [9:0]        y_i = '0;
    logic              wr_req_i = 1'b0;
    logic [ADDR_W-1:0] wr_addr_i = '0;
    logic [2:0]        wr_data_i = '0;
    logic              wr_ack_o;
    logic              wr_err_o;
    logic              mem_en_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [2:0]        mem_wdata_o;
    logic [2:0]        mem_rdata_i = '0;
    logic [2:0]        rgb_o;

    pixel_mem_arbiter #(
        .H_ACTIVE(H_ACTIVE), .H_TOTAL(H_TOTAL), .V_ACTIVE(V_ACTIVE),
        .V_TOTAL(V_TOTAL), .FB_W(FB_W), .ADDR_W(ADDR_W)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .x_i(x_i), .y_i(y_i),
        .wr_req_i(wr_req_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
        .wr_ack_o(wr_ack_o), .wr_err_o(wr_err_o),
        .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .rgb_o(rgb_o)
    );

    always #5 clk_i = ~clk_i;

    // Single-port memory, 1-cycle read latency.
    logic [2:0] mem [0:MEM_N-1];
    always @(posedge clk_i) begin
        if (mem_en_o) begin
            if (mem_we_o) mem[mem_addr_o] <= mem_wdata_o;
            else          mem_rdata_i     <= mem[mem_addr_o];
        end
    end

    // Reference state
    int shadow [0:MEM_N-1];
    int exp_ack, exp_err, exp_en, exp_we, exp_addr, exp_wdata;
    int cur_pix;
    int pq_c[$];
    int pq_v[$];
    int cyc;
    int cx, cy;
    int rst_req;
    int req, waddr, wdata, wmode, burst_n;
    int ack_seen;
    int chk_we;
    int sx, sy, srgb;
    int vectors, miscompares;

    localparam int WM_OFF = 0, WM_BURST = 1, WM_SINGLE = 2, WM_RAND = 3;

    task automatic check(input string tag, input int obs, input int exp);
        vectors++;
        if (obs != exp) begin
            miscompares++;
            $display("FAIL %s: observed %0d expected %0d (x=%0d y=%0d cyc=%0d)",
                     tag, obs, exp, cx, cy, cyc);
        end
    endtask

    task automatic model_reset();
        exp_ack = 0; exp_err = 0; exp_en = 0; exp_we = 0;
        exp_addr = 0; exp_wdata = 0; cur_pix = 0;
        pq_c.delete(); pq_v.delete();
    endtask

    task automatic new_rand();
        req = 1;
        if ($urandom % 8 == 0) waddr = DEPTH + int'($urandom % (MEM_N - DEPTH));
        else                   waddr = int'($urandom % DEPTH);
        wdata = int'($urandom % 8);
    endtask

    task automatic new_seq();
        req = 1; waddr = 1000 + burst_n; wdata = burst_n % 8; burst_n++;
    endtask

    // Writer holds a request until it sees the ack, then decides the next.
    task automatic writer_update();
        if (req != 0 && ack_seen != 0) begin
            case (wmode)
                WM_RAND:  if ($urandom % 2 == 0) new_rand(); else req = 0;
                WM_BURST: if (burst_n < 16) new_seq(); else req = 0;
                default:  req = 0;
            endcase
        end else if (req == 0 && wmode == WM_RAND && $urandom % 4 == 0) begin
            new_rand();
        end
    endtask

    // Arbitration rules from the raster position and the pending request.
    task automatic decide();
        int fx, fy, a;
        fx = (cx + 3) % H_TOTAL;
        fy = (cx + 3 >= H_TOTAL) ? (cy + 1) % V_TOTAL : cy;
        if (fx < H_ACTIVE && fy < V_ACTIVE && fx % 4 == 0) begin
            a = (fy / 4) * FB_W + fx / 4;
            exp_en = 1; exp_we = 0; exp_addr = a; exp_ack = 0; exp_err = 0;
            pq_c.push_back(cyc + 3);
            pq_v.push_back(shadow[a]);
        end else if (req != 0 && exp_ack == 0) begin
            exp_ack = 1;
            if (waddr >= DEPTH) begin
                exp_err = 1; exp_en = 0; exp_we = 0;
            end else begin
                exp_err = 0; exp_en = 1; exp_we = 1;
                exp_addr = waddr; exp_wdata = wdata;
            end
        end else begin
            exp_en = 0; exp_we = 0; exp_ack = 0; exp_err = 0;
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
        writer_update();
        rst_i     = (rst_req != 0);
        x_i       = 10'(cx);
        y_i       = 10'(cy);
        wr_req_i  = (req != 0);
        wr_addr_i = ADDR_W'(waddr);
        wr_data_i = 3'(wdata);
        @(negedge clk_i);
        cyc++;
        ack_seen = int'(wr_ack_o);
        check("ack", int'(wr_ack_o), exp_ack);
        check("err", int'(wr_err_o), exp_err);
        check("mem_en", int'(mem_en_o), exp_en);
        check("mem_we", int'(mem_we_o), exp_we);
        check("mem_addr", int'(mem_addr_o), exp_addr);
        check("mem_wdata", int'(mem_wdata_o), exp_wdata);
        chk_we = exp_en & exp_we;
        if (chk_we != 0) shadow[exp_addr] = exp_wdata;
        while (pq_c.size() > 0 && pq_c[0] == cyc) begin
            cur_pix = pq_v[0];
            void'(pq_c.pop_front());
            void'(pq_v.pop_front());
        end
        check("rgb", int'(rgb_o), (cx < H_ACTIVE && cy < V_ACTIVE) ? cur_pix : 0);
        if (rst_req != 0) decide();
        sx = cx; sy = cy; srgb = int'(rgb_o);
        cx++;
        if (cx == H_TOTAL) begin
            cx = 0;
            cy = (cy + 1) % V_TOTAL;
        end
    endtask

    task automatic goto_xy(input int x, input int y);
        cx = x; cy = y;
    endtask

    initial begin
        int n, m, seen;
        vectors = 0; miscompares = 0; cyc = 0;
        for (int i = 0; i < MEM_N; i++) begin
            mem[i] = 3'(i % 8);
            shadow[i] = i % 8;
        end
        rst_req = 0; req = 0; waddr = 0; wdata = 0; wmode = WM_OFF;
        burst_n = 0; ack_seen = 0; chk_we = 0;
        model_reset();
        goto_xy(700, 0);
        repeat (3) step();
        rst_req = 1;

        // Display order with untouched prefill (value = address mod 8)
        goto_xy(790, 524);
        repeat (20) begin
            step();
            if (sx == 0 && sy == 0) check("disp_0_0", srgb, 0);
            if (sx == 4 && sy == 0) check("disp_4_0", srgb, 1);
        end
        goto_xy(790, 3);
        repeat (20) begin
            step();
            if (sx == 0 && sy == 4) check("disp_0_4", srgb, 0);
            if (sx == 4 && sy == 4) check("disp_4_4", srgb, 1);
        end
        goto_xy(620, 476);
        repeat (30) begin
            step();
            if (sx == 636 && sy == 476) check("disp_636_476", srgb, 7);
            if (sx == 640 && sy == 476) check("disp_640_blank", srgb, 0);
        end
        goto_xy(790, 479);
        repeat (20) begin
            step();
            if (sx == 4 && sy == 480) check("disp_y480_blank", srgb, 0);
        end

        // Fetch cadence across line 10
        goto_xy(0, 10);
        n = 0;
        repeat (800) begin
            step();
            if (sx >= 1 && mem_en_o && !mem_we_o) n++;
            if (sx == 2)   check("fetch_x2_addr", int'(mem_addr_o), 321);
            if (sx == 634) check("fetch_x634_addr", int'(mem_addr_o), 479);
            if (sx == 798) begin
                check("fetch_x798_en", int'(mem_en_o), 1);
                check("fetch_x798_addr", int'(mem_addr_o), 320);
            end
        end
        check("fetch_count", n, 160);

        // Write held across a display slot
        goto_xy(0, 20);
        step();
        wmode = WM_SINGLE; req = 1; waddr = 5; wdata = 3;
        step();
        step();
        check("cont_slot_noack", int'(wr_ack_o), 0);
        step();
        check("cont_ack", int'(wr_ack_o), 1);
        check("cont_we", int'(mem_we_o), 1);
        check("cont_addr", int'(mem_addr_o), 5);
        n = 0;
        repeat (10) begin
            step();
            if (mem_en_o && mem_we_o) n++;
        end
        check("cont_single_we", n, 0);
        goto_xy(780, 524);
        repeat (50) begin
            step();
            if (sx == 20 && sy == 0) check("cont_readback", srgb, 3);
        end

        // Asynchronous reset with a freshly granted write in flight
        wmode = WM_OFF;
        goto_xy(396, 100);
        repeat (2) step();
        wmode = WM_SINGLE; req = 1; waddr = 7; wdata = 5;
        step();
        #1;
        rst_i = 1'b0; rst_req = 0;
        #1;
        check("rst_ack", int'(wr_ack_o), 0);
        check("rst_err", int'(wr_err_o), 0);
        check("rst_en", int'(mem_en_o), 0);
        check("rst_we", int'(mem_we_o), 0);
        check("rst_addr", int'(mem_addr_o), 0);
        check("rst_wdata", int'(mem_wdata_o), 0);
        check("rst_rgb", int'(rgb_o), 0);
        model_reset();
        repeat (3) step();
        rst_req = 1;
        seen = 0;
        repeat (2) begin
            step();
            if (wr_ack_o) seen = 1;
        end
        check("rst_ack_after_release", seen, 1);

        // Back-to-back writes during vertical blanking
        wmode = WM_OFF;
        goto_xy(100, 500);
        step();
        wmode = WM_BURST; burst_n = 0;
        new_seq();
        n = 0; m = 0;
        repeat (32) begin
            step();
            n += int'(wr_ack_o);
            if (mem_en_o && mem_we_o) m++;
        end
        check("burst_acks", n, 16);
        check("burst_writes", m, 16);

        // Out-of-range write
        wmode = WM_OFF;
        goto_xy(100, 510);
        step();
        wmode = WM_SINGLE; req = 1; waddr = DEPTH; wdata = 6;
        step();
        step();
        check("oob_ack", int'(wr_ack_o), 1);
        check("oob_err", int'(wr_err_o), 1);
        check("oob_en", int'(mem_en_o), 0);

        // Randomized segments
        for (int s = 0; s < 8; s++) begin
            wmode = WM_RAND;
            goto_xy(int'($urandom % H_TOTAL),
                    ($urandom % 4 == 0) ? 520 + int'($urandom % 5) : int'($urandom % V_TOTAL));
            repeat (1500) step();
        end
        wmode = WM_OFF;
        repeat (6) step();
        @(posedge clk_i);
        #1;
        n = 0;
        for (int i = 0; i < MEM_N; i++) begin
            if (int'(mem[i]) != shadow[i]) n++;
        end
        check("mem_final", n, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
